// File: rtl/vram_port_arbiter_if.sv
// Bundle of the two requester ports (CPU, DMA) and the shared RAM port A
// for vram_port_arbiter.
//   slave  : arbiter view - takes requests, drives acks/read data and mem_*.
//   master : requester/RAM view - drives requests and mem_dout.
// Signals:
//   cpu_req/cpu_wr_n/cpu_addr/cpu_din -> cpu_dout/cpu_ack  : Z80 bus side
//   dma_req/dma_wr_n/dma_addr/dma_din -> dma_dout/dma_ack  : debug/loader DMA
//   mem_en/mem_wr_n/mem_addr/mem_din  -> mem_dout          : RAM port A
//   owner                                                  : 0 = CPU, 1 = DMA
interface vram_port_arbiter_if;
  logic        cpu_req;
  logic        cpu_wr_n;
  logic [11:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;

  logic        dma_req;
  logic        dma_wr_n;
  logic [11:0] dma_addr;
  logic [7:0]  dma_din;
  logic [7:0]  dma_dout;
  logic        dma_ack;

  logic        mem_en;
  logic        mem_wr_n;
  logic [11:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;

  logic        owner;

  modport slave (
    input  cpu_req, cpu_wr_n, cpu_addr, cpu_din,
    output cpu_dout, cpu_ack,
    input  dma_req, dma_wr_n, dma_addr, dma_din,
    output dma_dout, dma_ack,
    output mem_en, mem_wr_n, mem_addr, mem_din,
    input  mem_dout,
    output owner
  );

  modport master (
    output cpu_req, cpu_wr_n, cpu_addr, cpu_din,
    input  cpu_dout, cpu_ack,
    output dma_req, dma_wr_n, dma_addr, dma_din,
    input  dma_dout, dma_ack,
    input  mem_en, mem_wr_n, mem_addr, mem_din,
    output mem_dout,
    input  owner
  );
endinterface

// File: rtl/vram_port_arbiter.sv
// Shares port A of the 4 KiB main RAM (tile, colour, sprite RAM 1) between
// the Z80 bus (primary) and a debug/loader DMA master (secondary).
// Each access: IDLE sample -> one ISSUE cycle with mem_en high -> read
// latency wait (reads only) -> one-cycle ack to the requester that won.
// All outputs are registered; mem_* is snooped downstream by the video
// block, so every write (including 0xFF0-0xFFF) appears as a normal cycle.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset
//   bus    : vram_port_arbiter_if.slave (requesters + RAM port A + owner)
// Parameters:
//   READ_LATENCY : edges from RAM address capture to valid mem_dout (1..4)
//   STARVE_MAX   : CPU grants allowed while DMA waits before DMA is forced (1..15)
module vram_port_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned STARVE_MAX   = 4
) (
  input logic               clk,
  input logic               resetn,
  vram_port_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT       = 3'd2;
  localparam logic [2:0] S_WRITE_DONE = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] LAT_LAST   = 2'(READ_LATENCY - 1);

  logic [2:0] state;
  logic [1:0] lat_cnt;
  logic [3:0] starve;
  logic       dma_wins;

  // DMA takes the port when it is alone, or when the CPU has had its quota.
  always_comb begin
    dma_wins = bus.dma_req && (!bus.cpu_req || (starve == STARVE_LIM));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      lat_cnt      <= '0;
      starve       <= '0;
      bus.mem_en   <= 1'b0;
      bus.mem_wr_n <= 1'b1;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
      bus.cpu_ack  <= 1'b0;
      bus.dma_ack  <= 1'b0;
      bus.cpu_dout <= '0;
      bus.dma_dout <= '0;
      bus.owner    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cpu_req || bus.dma_req) begin
            bus.owner  <= dma_wins;
            bus.mem_en <= 1'b1;
            state      <= S_ISSUE;
            if (dma_wins) begin
              bus.mem_wr_n <= bus.dma_wr_n;
              bus.mem_addr <= bus.dma_addr;
              bus.mem_din  <= bus.dma_din;
              starve       <= '0;
            end else begin
              bus.mem_wr_n <= bus.cpu_wr_n;
              bus.mem_addr <= bus.cpu_addr;
              bus.mem_din  <= bus.cpu_din;
              if (!bus.dma_req) begin
                starve <= '0;
              end else if (starve != STARVE_LIM) begin
                starve <= starve + 4'd1;
              end
            end
          end else begin
            starve <= '0;
          end
        end

        S_ISSUE: begin
          // mem_wr_n is only low here for a write, so it doubles as the
          // direction bit of the transaction in flight.
          bus.mem_en   <= 1'b0;
          bus.mem_wr_n <= 1'b1;
          lat_cnt      <= '0;
          if (!bus.mem_wr_n) begin
            bus.cpu_ack <= !bus.owner;
            bus.dma_ack <= bus.owner;
            state       <= S_WRITE_DONE;
          end else begin
            state <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            if (bus.owner) begin
              bus.dma_dout <= bus.mem_dout;
              bus.dma_ack  <= 1'b1;
            end else begin
              bus.cpu_dout <= bus.mem_dout;
              bus.cpu_ack  <= 1'b1;
            end
            state <= S_DONE;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        S_WRITE_DONE, S_DONE: begin
          bus.cpu_ack <= 1'b0;
          bus.dma_ack <= 1'b0;
          state       <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: two builds (READ_LATENCY=2 /
// STARVE_MAX=4 and READ_LATENCY=1 / STARVE_MAX=2), each with its own RAM,
// checked against a transaction-level model of the arbitration rules.
module tb_vram_port_arbiter;

  typedef struct packed {
    logic        cpu_req;
    logic        cpu_wr_n;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic        dma_req;
    logic        dma_wr_n;
    logic [11:0] dma_addr;
    logic [7:0]  dma_din;
  } drv_t;

  typedef struct packed {
    logic [7:0]  cpu_dout;
    logic        cpu_ack;
    logic [7:0]  dma_dout;
    logic        dma_ack;
    logic        mem_en;
    logic        mem_wr_n;
    logic [11:0] mem_addr;
    logic [7:0]  mem_din;
    logic        owner;
  } obs_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passes = 0;
  int checks = 0;

  vram_port_arbiter_if bus_a ();
  vram_port_arbiter_if bus_b ();

  vram_port_arbiter #(.READ_LATENCY(2), .STARVE_MAX(4)) dut_a (
    .clk(clk), .resetn(resetn), .bus(bus_a));
  vram_port_arbiter #(.READ_LATENCY(1), .STARVE_MAX(2)) dut_b (
    .clk(clk), .resetn(resetn), .bus(bus_b));

  drv_t drv_a, drv_b;
  assign bus_a.cpu_req  = drv_a.cpu_req;
  assign bus_a.cpu_wr_n = drv_a.cpu_wr_n;
  assign bus_a.cpu_addr = drv_a.cpu_addr;
  assign bus_a.cpu_din  = drv_a.cpu_din;
  assign bus_a.dma_req  = drv_a.dma_req;
  assign bus_a.dma_wr_n = drv_a.dma_wr_n;
  assign bus_a.dma_addr = drv_a.dma_addr;
  assign bus_a.dma_din  = drv_a.dma_din;
  assign bus_b.cpu_req  = drv_b.cpu_req;
  assign bus_b.cpu_wr_n = drv_b.cpu_wr_n;
  assign bus_b.cpu_addr = drv_b.cpu_addr;
  assign bus_b.cpu_din  = drv_b.cpu_din;
  assign bus_b.dma_req  = drv_b.dma_req;
  assign bus_b.dma_wr_n = drv_b.dma_wr_n;
  assign bus_b.dma_addr = drv_b.dma_addr;
  assign bus_b.dma_din  = drv_b.dma_din;

  obs_t obs_a, obs_b;
  assign obs_a = {bus_a.cpu_dout, bus_a.cpu_ack, bus_a.dma_dout, bus_a.dma_ack,
                  bus_a.mem_en, bus_a.mem_wr_n, bus_a.mem_addr, bus_a.mem_din, bus_a.owner};
  assign obs_b = {bus_b.cpu_dout, bus_b.cpu_ack, bus_b.dma_dout, bus_b.dma_ack,
                  bus_b.mem_en, bus_b.mem_wr_n, bus_b.mem_addr, bus_b.mem_din, bus_b.owner};

  // RAMs: A has a registered output (2 edges), B a plain synchronous read (1 edge).
  logic [7:0]  ram_a [4096];
  logic [7:0]  ram_b [4096];
  logic [7:0]  q_a;
  logic        bd_init = 1'b0;
  logic        bd_we = 1'b0;
  logic        bd_sel = 1'b0;
  logic [11:0] bd_addr = '0;
  logic [7:0]  bd_data = '0;

  function automatic logic [7:0] init_val(input int i, input int sel);
    return 8'(i * 37 + 11) ^ (sel != 0 ? 8'h5A : 8'h00);
  endfunction

  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 4096; i++) begin
        ram_a[i] <= init_val(i, 0);
        ram_b[i] <= init_val(i, 1);
      end
    end else begin
      if (bd_we) begin
        if (bd_sel) ram_b[bd_addr] <= bd_data;
        else        ram_a[bd_addr] <= bd_data;
      end
      if (bus_a.mem_en) begin
        if (!bus_a.mem_wr_n) ram_a[bus_a.mem_addr] <= bus_a.mem_din;
        q_a <= ram_a[bus_a.mem_addr];
      end
      if (bus_b.mem_en) begin
        if (!bus_b.mem_wr_n) ram_b[bus_b.mem_addr] <= bus_b.mem_din;
        bus_b.mem_dout <= ram_b[bus_b.mem_addr];
      end
    end
    bus_a.mem_dout <= q_a;
  end

  // Reference model state, per build.
  logic [7:0]  ref_a [4096];
  logic [7:0]  ref_b [4096];
  int          starve_m [2];
  logic        owner_m  [2];
  logic [11:0] addr_m   [2];
  logic [7:0]  din_m    [2];
  logic [7:0]  cdout_m  [2];
  logic [7:0]  ddout_m  [2];

  function automatic int rl(input int sel);
    return (sel != 0) ? 1 : 2;
  endfunction

  function automatic int sm(input int sel);
    return (sel != 0) ? 2 : 4;
  endfunction

  function automatic obs_t get_obs(input int sel);
    return (sel != 0) ? obs_b : obs_a;
  endfunction

  function automatic logic [7:0] ref_rd(input int sel, input logic [11:0] a);
    return (sel != 0) ? ref_b[a] : ref_a[a];
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      starve_m[s] = 0;
      owner_m[s]  = 1'b0;
      addr_m[s]   = '0;
      din_m[s]    = '0;
      cdout_m[s]  = '0;
      ddout_m[s]  = '0;
    end
  endtask

  task automatic chk_reset(input string tag, input int sel);
    obs_t e;
    e = '0;
    e.mem_wr_n = 1'b1;
    chk(tag, get_obs(sel), e);
  endtask

  task automatic set_fix(input int sel, input bit is_dma, input bit req, input bit wr_n,
                         input logic [11:0] a, input logic [7:0] v);
    drv_t d;
    d = (sel != 0) ? drv_b : drv_a;
    if (is_dma) begin
      d.dma_req = req; d.dma_wr_n = wr_n; d.dma_addr = a; d.dma_din = v;
    end else begin
      d.cpu_req = req; d.cpu_wr_n = wr_n; d.cpu_addr = a; d.cpu_din = v;
    end
    if (sel != 0) drv_b = d; else drv_a = d;
  endtask

  task automatic set_req(input int sel, input bit is_dma, input bit req);
    drv_t d;
    d = (sel != 0) ? drv_b : drv_a;
    if (is_dma) d.dma_req = req; else d.cpu_req = req;
    if (sel != 0) drv_b = d; else drv_a = d;
  endtask

  // New random transaction; small address pool so reads hit earlier writes,
  // half of them in the sprite-mirror window 0xFF0-0xFFF.
  task automatic set_op(input int sel, input bit is_dma);
    logic [11:0] a;
    a = (($urandom_range(0, 1) != 0) ? 12'hFF0 : 12'h200) | 12'($urandom_range(0, 15));
    set_fix(sel, is_dma, 1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom));
  endtask

  // One IDLE decision and, if anything is requested, the whole access.
  // Entered at posedge+1 of a cycle in which the DUT is in IDLE; leaves at
  // posedge+1 of the IDLE cycle that follows the ack.
  task automatic txn_round(input int sel, output bit granted, output bit win_dma);
    drv_t d;
    obs_t o;
    bit c, m, wr;
    logic [11:0] a;
    logic [7:0] v;
    int lat;
    d = (sel != 0) ? drv_b : drv_a;
    c = d.cpu_req;
    m = d.dma_req;
    granted = c | m;
    win_dma = 1'b0;
    if (!granted) begin
      @(negedge clk);
      o = get_obs(sel);
      chk("idle_mem_en", o.mem_en, 0);
      chk("idle_cpu_ack", o.cpu_ack, 0);
      chk("idle_dma_ack", o.dma_ack, 0);
      starve_m[sel] = 0;
      @(posedge clk); #1;
      return;
    end
    win_dma = m && (!c || starve_m[sel] == sm(sel));
    if (win_dma || !m) starve_m[sel] = 0;
    else if (starve_m[sel] < sm(sel)) starve_m[sel]++;
    wr  = win_dma ? !d.dma_wr_n : !d.cpu_wr_n;
    a   = win_dma ? d.dma_addr : d.cpu_addr;
    v   = win_dma ? d.dma_din  : d.cpu_din;
    lat = wr ? 2 : rl(sel) + 2;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      o = get_obs(sel);
      chk("mem_en", o.mem_en, k == 1);
      chk("mem_wr_n", o.mem_wr_n, !(k == 1 && wr));
      chk("mem_addr", o.mem_addr, (k == 0) ? addr_m[sel] : a);
      chk("mem_din", o.mem_din, (k == 0) ? din_m[sel] : v);
      chk("owner", o.owner, (k == 0) ? owner_m[sel] : win_dma);
      chk("cpu_ack", o.cpu_ack, (k == lat) && !win_dma);
      chk("dma_ack", o.dma_ack, (k == lat) && win_dma);
      if (k == lat) begin
        if (!wr && win_dma) ddout_m[sel] = ref_rd(sel, a);
        else if (!wr)       cdout_m[sel] = ref_rd(sel, a);
        chk("cpu_dout", o.cpu_dout, cdout_m[sel]);
        chk("dma_dout", o.dma_dout, ddout_m[sel]);
      end
    end
    addr_m[sel]  = a;
    din_m[sel]   = v;
    owner_m[sel] = win_dma;
    if (wr) begin
      if (sel != 0) ref_b[a] = v; else ref_a[a] = v;
    end
    @(posedge clk); #1;
  endtask

  // Request held high with fixed qualifiers: acks must recur at the minimum
  // spacing (write 3, read READ_LATENCY+3).
  task automatic b2b(input int sel, input bit is_dma, input bit wr,
                     input logic [11:0] a, input logic [7:0] v, input int n);
    obs_t o;
    int per;
    per = wr ? 3 : rl(sel) + 3;
    set_fix(sel, is_dma, 1'b1, !wr, a, v);
    for (int k = 0; k < n * per; k++) begin
      @(negedge clk);
      o = get_obs(sel);
      chk(is_dma ? "b2b_dma_ack" : "b2b_cpu_ack", is_dma ? o.dma_ack : o.cpu_ack,
          (k % per) == per - 1);
      if ((k % per) == per - 1 && !wr)
        chk("b2b_dout", is_dma ? o.dma_dout : o.cpu_dout, ref_rd(sel, a));
    end
    @(posedge clk); #1;
    set_req(sel, is_dma, 1'b0);
    if (wr) begin
      if (sel != 0) ref_b[a] = v; else ref_a[a] = v;
    end else if (is_dma) ddout_m[sel] = ref_rd(sel, a);
    else cdout_m[sel] = ref_rd(sel, a);
    addr_m[sel] = a;
    din_m[sel] = v;
    owner_m[sel] = is_dma;
    starve_m[sel] = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit g, w;
    drv_t d;
    drv_a = '0; drv_a.cpu_wr_n = 1'b1; drv_a.dma_wr_n = 1'b1;
    drv_b = drv_a;
    model_reset();
    for (int i = 0; i < 4096; i++) begin
      ref_a[i] = init_val(i, 0);
      ref_b[i] = init_val(i, 1);
    end

    // Reset state while reset is held, RAM contents initialised meanwhile.
    bd_init = 1'b1;
    @(posedge clk); #1;
    bd_init = 1'b0;
    @(posedge clk); #1;
    chk_reset("reset_a", 0);
    chk_reset("reset_b", 1);
    bd_we = 1'b1; bd_sel = 1'b0; bd_addr = 12'h3A5; bd_data = 8'h5C;
    ref_a[12'h3A5] = 8'h5C;
    @(posedge clk); #1;
    bd_we = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk_reset("post_reset_a", 0);

    // CPU read of a preloaded location.
    set_fix(0, 1'b0, 1'b1, 1'b1, 12'h3A5, 8'h00);
    txn_round(0, g, w);
    set_req(0, 1'b0, 1'b0);
    chk("t1_cpu_dout", obs_a.cpu_dout, 8'h5C);
    chk("t1_owner", obs_a.owner, 0);

    // DMA write into the sprite window, then CPU reads it back.
    set_fix(0, 1'b1, 1'b1, 1'b0, 12'hFF3, 8'hA7);
    txn_round(0, g, w);
    set_req(0, 1'b1, 1'b0);
    chk("t2_owner_dma", obs_a.owner, 1);
    set_fix(0, 1'b0, 1'b1, 1'b1, 12'hFF3, 8'h00);
    txn_round(0, g, w);
    set_req(0, 1'b0, 1'b0);
    chk("t2_owner_cpu", obs_a.owner, 0);
    chk("t2_cpu_dout", obs_a.cpu_dout, 8'hA7);

    // Simultaneous first request with the starve count at zero.
    txn_round(0, g, w);
    set_fix(0, 1'b0, 1'b1, 1'b1, 12'h010, 8'h00);
    set_fix(0, 1'b1, 1'b1, 1'b0, 12'h011, 8'h3C);
    txn_round(0, g, w);
    chk("t3_first_cpu", obs_a.owner, 0);
    set_req(0, 1'b0, 1'b0);
    txn_round(0, g, w);
    chk("t3_then_dma", obs_a.owner, 1);
    set_req(0, 1'b1, 1'b0);

    // Starvation: both held continuously -> CPU x4, DMA, repeating.
    txn_round(0, g, w);
    set_op(0, 1'b0);
    set_op(0, 1'b1);
    for (int i = 0; i < 15; i++) begin
      txn_round(0, g, w);
      chk("starve_order_a", obs_a.owner, (i % 5) == 4);
      set_op(0, w);
    end
    set_req(0, 1'b0, 1'b0);
    set_req(0, 1'b1, 1'b0);
    txn_round(0, g, w);

    // Build B: READ_LATENCY=1, STARVE_MAX=2.
    set_fix(1, 1'b0, 1'b1, 1'b1, 12'h123, 8'h00);
    txn_round(1, g, w);
    set_req(1, 1'b0, 1'b0);
    b2b(1, 1'b0, 1'b0, 12'h456, 8'h00, 3);
    b2b(1, 1'b1, 1'b1, 12'hFF8, 8'h96, 3);
    b2b(0, 1'b0, 1'b0, 12'hFF8, 8'h00, 2);
    txn_round(1, g, w);
    set_op(1, 1'b0);
    set_op(1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      txn_round(1, g, w);
      chk("starve_order_b", obs_b.owner, (i % 3) == 2);
      set_op(1, w);
    end
    set_req(1, 1'b0, 1'b0);
    set_req(1, 1'b1, 1'b0);
    txn_round(1, g, w);

    // Reset pulsed during WAIT of a CPU read on build A.
    set_fix(0, 1'b0, 1'b1, 1'b1, 12'h3A5, 8'h00);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk_reset("rst_wait_a", 0);
    chk_reset("rst_wait_b", 1);
    @(posedge clk); #1;
    chk_reset("rst_hold_a", 0);
    @(negedge clk);
    chk_reset("rst_hold2_a", 0);
    @(posedge clk); #1;
    model_reset();
    resetn = 1'b1;
    txn_round(0, g, w);
    set_req(0, 1'b0, 1'b0);
    chk("rst_then_read", obs_a.cpu_dout, 8'h5C);

    // Randomised traffic on both builds.
    for (int sel = 0; sel < 2; sel++) begin
      for (int n = 0; n < ((sel != 0) ? 40 : 80); n++) begin
        d = (sel != 0) ? drv_b : drv_a;
        if (!d.cpu_req && $urandom_range(0, 2) != 0) set_op(sel, 1'b0);
        if (!d.dma_req && $urandom_range(0, 2) == 0) set_op(sel, 1'b1);
        txn_round(sel, g, w);
        if (g) begin
          if ($urandom_range(0, 3) == 0) set_req(sel, w, 1'b0);
          else set_op(sel, w);
        end
      end
      set_req(sel, 1'b0, 1'b0);
      set_req(sel, 1'b1, 1'b0);
      txn_round(sel, g, w);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
